// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative RV64M multiplier:
// op encodings, FSM states and datapath width.
package seq_multiplier_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

endpackage

// File: rtl/seq_multiplier_adder.sv
// ALU carry-propagate adder/subtractor; the multiplier uses
// it add-only and takes c_o as the 65th sum bit.
module adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         c_o
);

  logic [W-1:0] b_x;

  assign b_x = b ^ {W{sub}};
  assign {c_o, sum} = {1'b0, a} + {1'b0, b_x}
                    + {{W{1'b0}}, sub};

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU,
// fixed 66-cycle latency, valid/ready on both sides.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int XW    = XLEN,
  parameter int CNT_W = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [1:0]    op_i,
  input  logic [XW-1:0] rs1_i,
  input  logic [XW-1:0] rs2_i,
  input  logic          flush_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [XW-1:0] result_o
);

  localparam int PW = 2 * XW;

  state_t state, state_d;

  logic [1:0]    op_q;
  logic          neg_res;
  logic [XW-1:0] a_mag;
  logic [XW-1:0] hi;
  logic [XW-1:0] lo;
  logic [CNT_W-1:0] cnt;

  logic          accept;
  logic          last;
  logic          a_neg;
  logic          b_neg;
  logic [XW-1:0] a_mag_d;
  logic [XW-1:0] b_mag_d;
  logic [XW-1:0] addend;
  logic [XW-1:0] sum;
  logic          c;
  logic [PW-1:0] prod;
  logic [PW-1:0] prod_fin;

  assign accept = valid_i & ready_o & ~flush_i;
  assign last   = (cnt == CNT_W'(XW - 1));

  assign a_neg = rs1_i[XW-1] & (op_i != MUL_OP_MULHU);
  assign b_neg = rs2_i[XW-1]
               & ((op_i == MUL_OP_MUL) | (op_i == MUL_OP_MULH));

  // -2^63 negates to itself, which reads correctly as unsigned 2^63
  assign a_mag_d = a_neg ? (~rs1_i + XW'(1)) : rs1_i;
  assign b_mag_d = b_neg ? (~rs2_i + XW'(1)) : rs2_i;

  assign addend = lo[0] ? a_mag : '0;

  adder #(.W(XW)) u_adder (
    .a   (hi),
    .b   (addend),
    .sub (1'b0),
    .sum (sum),
    .c_o (c)
  );

  assign prod     = {hi, lo};
  assign prod_fin = neg_res ? (~prod + PW'(1)) : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) state_d = CALC;
      end
      CALC: begin
        if (flush_i)   state_d = IDLE;
        else if (last) state_d = SIGN;
      end
      SIGN: begin
        state_d = flush_i ? IDLE : DONE;
      end
      DONE: begin
        valid_o = 1'b1;
        if (flush_i | ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      neg_res  <= 1'b0;
      a_mag    <= '0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      result_o <= '0;
    end else if (accept) begin
      op_q    <= op_i;
      neg_res <= a_neg ^ b_neg;
      a_mag   <= a_mag_d;
      hi      <= '0;
      lo      <= b_mag_d;
      cnt     <= '0;
    end else if (!flush_i) begin
      unique case (state)
        CALC: begin
          hi  <= {c, sum[XW-1:1]};
          lo  <= {sum[0], lo[XW-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        SIGN: begin
          hi <= prod_fin[PW-1:XW];
          lo <= prod_fin[XW-1:0];
          result_o <= (op_q == MUL_OP_MUL) ? prod_fin[XW-1:0]
                                           : prod_fin[PW-1:XW];
        end
        default: ;
      endcase
    end
  end

endmodule
